// File: rtl/biquad8_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | biquad8_pkg : register map, coefficient width and loader FSM states shared |
// | by the biquad8 coefficient loader.                     Revision: 1.0       |
// +---------------------------------------------------------------------------+
package biquad8_pkg;

    localparam logic [6:0] REG_UPDATE  = 7'h00;
    localparam logic [6:0] REG_FIR     = 7'h04;
    localparam logic [6:0] REG_IIR     = 7'h08;
    localparam logic [6:0] REG_INC     = 7'h0C;
    localparam logic [6:0] REG_POLEFIR = 7'h10;

    localparam int COEF_W   = 18;
    localparam int WB_ADR_W = 7;
    localparam int ENTRY_W  = WB_ADR_W + COEF_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WRITE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_UPDATE = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

endpackage
`default_nettype wire

// File: rtl/biquad8_coeff_table.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | biquad8_coeff_table : DEPTH x WIDTH simple dual-port RAM, registered read. |
// |                                                        Revision: 1.0       |
// +---------------------------------------------------------------------------+
module biquad8_coeff_table #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Contents are deliberately not reset; the host reloads them as needed.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
        rd_data_q <= mem_q[i_rd_addr];
    end

    assign o_rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/biquad8_coeff_loader.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | biquad8_coeff_loader : WISHBONE master replaying a stored coefficient      |
// | program into the biquad8 wrapper control target.       Revision: 1.0       |
// +---------------------------------------------------------------------------+
module biquad8_coeff_loader
    import biquad8_pkg::*;
#(
    parameter int DEPTH      = 32,
    parameter int AW         = 5,
    parameter int TIMEOUT    = 255,
    parameter int GAP_CYCLES = 2
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          tbl_wr_i,
    input  logic [AW-1:0] tbl_adr_i,
    input  logic [24:0]   tbl_dat_i,
    input  logic          start_i,
    input  logic [AW:0]   len_i,
    input  logic          auto_update_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          timeout_o,
    output logic          m_wb_cyc_o,
    output logic          m_wb_stb_o,
    output logic          m_wb_we_o,
    output logic [6:0]    m_wb_adr_o,
    output logic [31:0]   m_wb_dat_o,
    output logic [3:0]    m_wb_sel_o,
    input  logic          m_wb_ack_i,
    input  logic          m_wb_err_i
);

    localparam int                TCNT_W   = $clog2(TIMEOUT + 1);
    localparam int                GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [AW:0]       LEN_MAX  = (AW + 1)'(DEPTH);
    localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_e              state_q, state_d;
    logic [AW:0]         idx_q, idx_d;
    logic [AW:0]         len_q, len_d;
    logic                auto_q, auto_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [GAP_W-1:0]    gcnt_q, gcnt_d;
    logic                cyc_q, cyc_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                tout_q, tout_d;

    logic [AW:0]         w_len_clamped;
    logic [ENTRY_W-1:0]  w_entry;
    logic                w_in_write;
    logic                w_in_update;

    biquad8_coeff_table #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIDTH (ENTRY_W)
    ) u_table (
        .clk       (wb_clk_i),
        .i_wr_en   (tbl_wr_i && !busy_q),
        .i_wr_addr (tbl_adr_i),
        .i_wr_data (tbl_dat_i),
        .i_rd_addr (idx_q[AW-1:0]),
        .o_rd_data (w_entry)
    );

    assign w_len_clamped = (len_i > LEN_MAX) ? LEN_MAX : len_i;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        auto_d  = auto_q;
        tcnt_d  = '0;
        gcnt_d  = '0;
        cyc_d   = cyc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tout_d  = tout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    len_d  = w_len_clamped;
                    auto_d = auto_update_i;
                    tout_d = 1'b0;
                    idx_d  = '0;
                    busy_d = 1'b1;
                    if (w_len_clamped != '0) begin
                        state_d = ST_FETCH;
                    end else if (auto_update_i) begin
                        state_d = ST_UPDATE;
                        cyc_d   = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_FETCH: begin
                state_d = ST_WRITE;
                cyc_d   = 1'b1;
            end
            ST_WRITE, ST_UPDATE: begin
                // err outranks a coincident ack; a late ack at the limit still completes
                if (m_wb_err_i || (!m_wb_ack_i && (tcnt_q == TCNT_MAX))) begin
                    cyc_d   = 1'b0;
                    tout_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (m_wb_ack_i) begin
                    cyc_d = 1'b0;
                    if (state_q == ST_WRITE) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gcnt_q == GAP_LAST) begin
                    if (idx_q < len_q) begin
                        state_d = ST_FETCH;
                    end else if (auto_q) begin
                        state_d = ST_UPDATE;
                        cyc_d   = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            auto_q  <= 1'b0;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
            cyc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            auto_q  <= auto_d;
            tcnt_q  <= tcnt_d;
            gcnt_q  <= gcnt_d;
            cyc_q   <= cyc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tout_q  <= tout_d;
        end
    end

    assign w_in_write  = (state_q == ST_WRITE);
    assign w_in_update = (state_q == ST_UPDATE);

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign timeout_o  = tout_q;
    assign m_wb_cyc_o = cyc_q;
    assign m_wb_stb_o = cyc_q;
    assign m_wb_we_o  = cyc_q;

    // Entry data comes straight off the RAM read register, which holds while idx is stable.
    assign m_wb_adr_o = w_in_write ? (w_entry[ENTRY_W-1:COEF_W] & 7'h7C) : REG_UPDATE;
    assign m_wb_dat_o = w_in_write  ? {{(32 - COEF_W){1'b0}}, w_entry[COEF_W-1:0]} :
                        w_in_update ? 32'h1 : 32'h0;
    assign m_wb_sel_o = w_in_write  ? 4'hF :
                        w_in_update ? 4'h1 : 4'h0;

endmodule
`default_nettype wire

// File: tb/tb_biquad8_coeff_loader.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_biquad8_coeff_loader : self-checking bench with a WISHBONE responder    |
// | and a list-based model of the expected write sequence.  Revision: 1.0      |
// +---------------------------------------------------------------------------+
module tb_biquad8_coeff_loader;

    localparam int DEPTH       = 32;
    localparam int TIMEOUT     = 255;
    localparam int GAP         = 2;
    localparam int MODE_OK     = 0;
    localparam int MODE_SILENT = 1;
    localparam int MODE_ERR    = 2;

    typedef struct packed {
        logic [6:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wr_t;

    typedef struct {
        int len;
        bit au;
        int lat;
        int exp_writes;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tbl_wr_i = 1'b0;
    logic [4:0]  tbl_adr_i = '0;
    logic [24:0] tbl_dat_i = '0;
    logic        start_i = 1'b0;
    logic [5:0]  len_i = '0;
    logic        auto_update_i = 1'b0;
    logic        busy_o, done_o, timeout_o;
    logic        m_wb_cyc_o, m_wb_stb_o, m_wb_we_o;
    logic [6:0]  m_wb_adr_o;
    logic [31:0] m_wb_dat_o;
    logic [3:0]  m_wb_sel_o;
    logic        m_wb_ack, m_wb_err;
    logic        resp_ack = 1'b0;
    logic        resp_err = 1'b0;
    logic        inj_ack = 1'b0;

    assign m_wb_ack = resp_ack | inj_ack;
    assign m_wb_err = resp_err;

    biquad8_coeff_loader #(
        .DEPTH      (DEPTH),
        .AW         (5),
        .TIMEOUT    (TIMEOUT),
        .GAP_CYCLES (GAP)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .tbl_wr_i      (tbl_wr_i),
        .tbl_adr_i     (tbl_adr_i),
        .tbl_dat_i     (tbl_dat_i),
        .start_i       (start_i),
        .len_i         (len_i),
        .auto_update_i (auto_update_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .timeout_o     (timeout_o),
        .m_wb_cyc_o    (m_wb_cyc_o),
        .m_wb_stb_o    (m_wb_stb_o),
        .m_wb_we_o     (m_wb_we_o),
        .m_wb_adr_o    (m_wb_adr_o),
        .m_wb_dat_o    (m_wb_dat_o),
        .m_wb_sel_o    (m_wb_sel_o),
        .m_wb_ack_i    (m_wb_ack),
        .m_wb_err_i    (m_wb_err)
    );

    always #5 clk = ~clk;

    int cyc_num = 0;
    always @(posedge clk) cyc_num <= cyc_num + 1;

    // Stimulus-side knobs (written only by the main initial block)
    int run_id = 0;
    int lat = 1;
    int mode = MODE_OK;
    int err_at = 0;

    // Monitor/responder state (written only by the negedge process)
    wr_t  log_q[$];
    int   mon_run = 0;
    int   rise_cnt = 0, min_gap = 1000, low_run = 0, txn = 0, wcnt = 0;
    int   cyc_len = 0, last_cyc_run = 0, done_run = 0, done_cyc = 0;
    int   viol = 0, db_bad = 0;
    bit   had_stb = 0, prev_cyc = 0, prev_stb = 0, prev_busy = 0, was_acked = 0;
    logic [42:0] prev_bus = '0;

    always @(negedge clk) begin
        if (mon_run != run_id) begin
            mon_run = run_id;
            log_q.delete();
            rise_cnt = 0; min_gap = 1000; low_run = 0; had_stb = 0;
            txn = 0; last_cyc_run = 0; done_run = 0;
        end
        was_acked = resp_ack | resp_err;
        if (m_wb_cyc_o) begin
            if (!m_wb_stb_o || !m_wb_we_o || m_wb_adr_o[1:0] != 2'b00) viol++;
            if (prev_cyc && !was_acked && {m_wb_adr_o, m_wb_dat_o, m_wb_sel_o} != prev_bus) viol++;
            cyc_len++;
        end else begin
            if (m_wb_stb_o || m_wb_we_o) viol++;
            if (prev_cyc) last_cyc_run = cyc_len;
            cyc_len = 0;
        end
        if (m_wb_stb_o && !prev_stb) begin
            rise_cnt++;
            if (had_stb && low_run < min_gap) min_gap = low_run;
            had_stb = 1;
        end
        if (!m_wb_stb_o) low_run++; else low_run = 0;
        if (done_o) begin
            done_run++;
            done_cyc = cyc_num;
            if (busy_o || !prev_busy) db_bad++;
        end
        // responder: drives ack/err for the coming rising edge
        if (rst || was_acked) begin
            resp_ack = 1'b0; resp_err = 1'b0; wcnt = 0;
        end else if (m_wb_cyc_o && m_wb_stb_o && mode != MODE_SILENT) begin
            if (wcnt >= lat - 1) begin
                resp_ack = 1'b1;
                if (mode == MODE_ERR && txn == err_at) resp_err = 1'b1;
                else log_q.push_back({m_wb_adr_o, m_wb_dat_o, m_wb_sel_o});
                txn++;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
        prev_cyc  = m_wb_cyc_o;
        prev_stb  = m_wb_stb_o;
        prev_busy = busy_o;
        prev_bus  = {m_wb_adr_o, m_wb_dat_o, m_wb_sel_o};
    end

    int          vectors = 0;
    int          miscompares = 0;
    logic [24:0] shadow [DEPTH];
    wr_t         exp_q[$];
    int          start_cyc = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tbl_write(input int idx, input logic [24:0] ent);
        tbl_wr_i = 1'b1; tbl_adr_i = 5'(idx); tbl_dat_i = ent;
        tick();
        tbl_wr_i = 1'b0;
        shadow[idx] = ent;
    endtask

    // Expected bus writes: one per (clamped) entry in order, then the optional update.
    task automatic build_exp(input int len, input bit au);
        int n;
        exp_q.delete();
        n = (len > DEPTH) ? DEPTH : len;
        for (int i = 0; i < n; i++)
            exp_q.push_back({shadow[i][24:18] & 7'h7C, 14'd0, shadow[i][17:0], 4'hF});
        if (au) exp_q.push_back({7'h00, 32'h1, 4'h1});
    endtask

    task automatic launch(input int len, input bit au);
        run_id++;
        start_cyc = cyc_num;
        len_i = 6'(len); auto_update_i = au; start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int n = 0;
        while (busy_o && n < budget) begin
            tick();
            n++;
        end
        ok = !busy_o;
        tick();
        tick();
    endtask

    task automatic check_run(input string tag, input int len, input bit au, input bit ok);
        build_exp(len, au);
        check({tag, "/finished"}, 64'(ok), 64'd1);
        check({tag, "/nwrites"}, 64'(log_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < log_q.size())
                check($sformatf("%s/wr%0d", tag, i), 64'(log_q[i]), 64'(exp_q[i]));
        check({tag, "/done"}, 64'(done_run), 64'd1);
        check({tag, "/timeout"}, 64'(timeout_o), 64'd0);
        check({tag, "/protocol"}, 64'(viol), 64'd0);
        check({tag, "/done_busy"}, 64'(db_bad), 64'd0);
        if (exp_q.size() > 1) check({tag, "/gap"}, 64'(min_gap >= GAP), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want $finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        bit   ok;
        int   n;
        vecs[0] = '{3,  1'b1, 6, 4};
        vecs[1] = '{0,  1'b0, 1, 0};
        vecs[2] = '{0,  1'b1, 3, 1};
        vecs[3] = '{1,  1'b0, 1, 1};
        vecs[4] = '{40, 1'b0, 1, 32};
        vecs[5] = '{32, 1'b1, 2, 33};

        tick(); tick(); tick();
        check("reset/outputs", {m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, m_wb_adr_o, m_wb_dat_o,
                                m_wb_sel_o, busy_o, done_o, timeout_o}, 64'd0);
        rst = 1'b0;
        tick();

        tbl_write(0, {7'h04, 18'h00123});
        tbl_write(1, {7'h08, 18'h3FFFF});
        tbl_write(2, {7'h10, 18'h00001});
        for (int i = 3; i < DEPTH; i++) tbl_write(i, 25'($urandom));

        for (int v = 0; v < 6; v++) begin
            lat = vecs[v].lat;
            launch(vecs[v].len, vecs[v].au);
            wait_idle(2000, ok);
            check_run($sformatf("vec%0d", v), vecs[v].len, vecs[v].au, ok);
            check($sformatf("vec%0d/count", v), 64'(log_q.size()), 64'(vecs[v].exp_writes));
            check($sformatf("vec%0d/stb_rises", v), 64'(rise_cnt), 64'(vecs[v].exp_writes));
            if (vecs[v].exp_writes == 0)
                check($sformatf("vec%0d/done_latency_ok", v), 64'((done_cyc - start_cyc) <= 2), 64'd1);
        end

        // Silent target: abort after TIMEOUT+1 strobe cycles, then a healthy retry clears the flag.
        mode = MODE_SILENT;
        launch(2, 1'b1);
        wait_idle(600, ok);
        check("to/finished", 64'(ok), 64'd1);
        check("to/cyc_len", 64'(last_cyc_run), 64'(TIMEOUT + 1));
        check("to/flag", 64'(timeout_o), 64'd1);
        check("to/no_done", 64'(done_run), 64'd0);
        check("to/nwrites", 64'(log_q.size()), 64'd0);
        mode = MODE_OK; lat = 2;
        launch(2, 1'b1);
        check("to/cleared", 64'(timeout_o), 64'd0);
        wait_idle(400, ok);
        check_run("retry", 2, 1'b1, ok);

        // err (with a coincident ack) on the second entry aborts; a late ack changes nothing.
        mode = MODE_ERR; err_at = 1; lat = 3;
        launch(3, 1'b1);
        wait_idle(400, ok);
        build_exp(3, 1'b1);
        check("err/finished", 64'(ok), 64'd1);
        check("err/flag", 64'(timeout_o), 64'd1);
        check("err/no_done", 64'(done_run), 64'd0);
        check("err/nwrites", 64'(log_q.size()), 64'd1);
        if (log_q.size() > 0) check("err/wr0", 64'(log_q[0]), 64'(exp_q[0]));
        inj_ack = 1'b1; tick(); inj_ack = 1'b0; tick(); tick();
        check("err/late_ack", {m_wb_cyc_o, busy_o, done_o, timeout_o}, 64'b0001);
        check("err/late_rises", 64'(rise_cnt), 64'd2);
        check("err/late_done", 64'(done_run), 64'd0);
        mode = MODE_OK;

        // Reset while in WRITE; start and table writes issued while busy must be ignored.
        lat = 20;
        launch(3, 1'b0);
        n = 0;
        while (!m_wb_cyc_o && n < 20) begin
            tick();
            n++;
        end
        check("rst/in_write", 64'(m_wb_cyc_o), 64'd1);
        start_i = 1'b1; len_i = 6'd1;
        tbl_wr_i = 1'b1; tbl_adr_i = 5'd0; tbl_dat_i = 25'h1ABCDE;
        tick();
        start_i = 1'b0; tbl_wr_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("rst/outputs", {m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, m_wb_adr_o, m_wb_dat_o,
                              m_wb_sel_o, busy_o, done_o, timeout_o}, 64'd0);
        rst = 1'b0;
        inj_ack = 1'b1; tick(); inj_ack = 1'b0; tick(); tick();
        check("rst/after", {m_wb_cyc_o, busy_o, done_o}, 64'd0);
        check("rst/no_done", 64'(done_run), 64'd0);
        lat = 1;
        launch(3, 1'b0);
        wait_idle(400, ok);
        check_run("reread", 3, 1'b0, ok);

        // Randomized programs against the list model.
        for (int r = 0; r < 8; r++) begin
            int rl;
            bit ra;
            for (int k = 0; k < 4; k++) tbl_write(int'($urandom_range(0, DEPTH - 1)), 25'($urandom));
            rl  = int'($urandom_range(0, 40));
            ra  = 1'($urandom_range(0, 1));
            lat = int'($urandom_range(1, 5));
            launch(rl, ra);
            wait_idle(1000, ok);
            check_run($sformatf("rand%0d", r), rl, ra, ok);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
